// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg
// Shared types and sizing helpers for the banked synchronous RAM.
//   state_t     : controller state (INIT zero-fill, RUN service requests)
//   bank_sel_w  : number of upper address bits that pick the bank
//   row_w       : number of low address bits that index a row inside a bank
//   lane_w      : width of one write-strobed sub-word lane
package banked_ram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int bank_sel_w(input int banks);
      return $clog2(banks);
   endfunction

   function automatic int row_w(input int addr_width, input int banks);
      return addr_width - $clog2(banks);
   endfunction

   function automatic int lane_w(input int data_width, input int lanes);
      return data_width / lanes;
   endfunction

endpackage

// File: rtl/bank_ram.sv
// bank_ram
// One lane array of a bank: ROWS entries of W bits, synchronous write and
// registered read. The read register only updates on a read, so it keeps the
// last word read while the lane is idle or being written.
//   clk   : clock
//   cs    : lane select
//   we    : 1 = write wdata to row, 0 = read row into rdata
//   row   : row index
//   wdata : write data
//   rdata : registered read data
module bank_ram #(
   parameter int W     = 8,
   parameter int ROWS  = 4096,
   parameter int ROW_W = 12
) (
   input  logic             clk,
   input  logic             cs,
   input  logic             we,
   input  logic [ROW_W-1:0] row,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (cs && we) begin
         mem[row] <= wdata;
      end
      if (cs && !we) begin
         rdata <= mem[row];
      end
   end

endmodule

// File: rtl/banked_sync_ram.sv
// banked_sync_ram
// Single-port synchronous RAM made of BANKS x LANES bank_ram lane arrays.
// After reset every row of every bank is zero-filled in parallel, one row per
// cycle; then one request per cycle is accepted and reads answer one cycle
// later. Optional feature macro: BANKED_RAM_PARITY_EN adds an even-parity bit
// per lane and the parity_err output.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : request can be accepted (low during reset and init)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address, upper bits = bank, lower bits = row
//   req_wstrb  : per-lane write enable
//   req_wdata  : write data
//   rsp_valid  : one-cycle pulse with read data
//   rsp_rdata  : read data, holds its last value between responses
//   rsp_bank   : bank the response came from
//   init_done  : zero-fill finished
//   parity_err : lane parity mismatch on this response (parity build only)
module banked_sync_ram
   import banked_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 16,
   parameter int BANKS      = 4,
   parameter int LANES      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   input  logic [LANES-1:0]              req_wstrb,
   input  logic [DATA_WIDTH-1:0]         req_wdata,
   output logic                          rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [bank_sel_w(BANKS)-1:0]  rsp_bank,
   output logic                          init_done
`ifdef BANKED_RAM_PARITY_EN
   ,
   output logic                          parity_err
`endif
);

   localparam int BSW    = bank_sel_w(BANKS);
   localparam int ROW_W  = row_w(ADDR_WIDTH, BANKS);
   localparam int ROWS   = 1 << ROW_W;
   localparam int LANE_W = lane_w(DATA_WIDTH, LANES);
`ifdef BANKED_RAM_PARITY_EN
   localparam int MEM_W  = LANE_W + 1;
`else
   localparam int MEM_W  = LANE_W;
`endif

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic lane_par(input logic [LANE_W-1:0] d);
      return ^d;
   endfunction

   state_t                          state;
   logic [ROW_W-1:0]                init_row;
   logic                            run_q;
   logic                            vld_p1;
   logic [BSW-1:0]                  bank_p1;
   logic [DATA_WIDTH-1:0]           hold_p1;

   logic                            accept;
   logic                            filling;
   logic [BSW-1:0]                  bank_sel;
   logic [ROW_W-1:0]                row_sel;
   logic [BANKS-1:0][DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0]           mux_data;
`ifdef BANKED_RAM_PARITY_EN
   logic [BANKS-1:0][LANES-1:0]     rd_perr;
`endif

   // A request arriving in the same cycle as rst is dropped.
   assign accept   = req_valid && run_q && !rst;
   assign filling  = (state == INIT);
   assign bank_sel = req_addr[ADDR_WIDTH-1 -: BSW];
   assign row_sel  = req_addr[ROW_W-1:0];

   // ---- stage p0: bank decode and lane array access ----
   for (genvar b = 0; b < BANKS; b++) begin : gen_bank
      logic hit;
      assign hit = accept && (bank_sel == BSW'(b));

      for (genvar l = 0; l < LANES; l++) begin : gen_lane
         logic              cs;
         logic              we;
         logic [ROW_W-1:0]  row;
         logic [LANE_W-1:0] wlane;
         logic [MEM_W-1:0]  wdata;
         logic [MEM_W-1:0]  rdata;

         assign wlane = req_wdata[l*LANE_W +: LANE_W];
         // Reads enable every lane of the bank; writes only strobed lanes.
         assign cs    = filling || (hit && (!req_we || req_wstrb[l]));
         assign we    = filling || req_we;
         assign row   = filling ? init_row : row_sel;
`ifdef BANKED_RAM_PARITY_EN
         assign wdata = filling ? '0 : {lane_par(wlane), wlane};
         assign rd_data[b][l*LANE_W +: LANE_W] = rdata[LANE_W-1:0];
         assign rd_perr[b][l] = rdata[LANE_W] != lane_par(rdata[LANE_W-1:0]);
`else
         assign wdata = filling ? '0 : wlane;
         assign rd_data[b][l*LANE_W +: LANE_W] = rdata;
`endif

         bank_ram #(
            .W     (MEM_W),
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
         ) u_lane (
            .clk   (clk),
            .cs    (cs),
            .we    (we),
            .row   (row),
            .wdata (wdata),
            .rdata (rdata)
         );
      end
   end

   // ---- stage p1: response from the bank registered with the read ----
   assign mux_data  = rd_data[bank_p1];
   assign rsp_valid = vld_p1;
   assign rsp_rdata = vld_p1 ? mux_data : hold_p1;
   assign rsp_bank  = bank_p1;
   assign req_ready = run_q;
   assign init_done = run_q;
`ifdef BANKED_RAM_PARITY_EN
   assign parity_err = vld_p1 && (|rd_perr[bank_p1]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_row <= '0;
         run_q    <= 1'b0;
         vld_p1   <= 1'b0;
         bank_p1  <= '0;
         hold_p1  <= '0;
      end else begin
         vld_p1 <= accept && !req_we;
         if (accept && !req_we) begin
            bank_p1 <= bank_sel;
         end
         if (vld_p1) begin
            hold_p1 <= mux_data;
         end
         case (state)
            INIT: begin
               init_row <= init_row + 1'b1;
               if (init_row == '1) begin
                  state <= RUN;
                  run_q <= 1'b1;
               end
            end
            RUN:     state <= RUN;
            default: state <= INIT;
         endcase
      end
   end

endmodule
